// File: rtl/sram_pkg.sv
// Shared constants and types for the two-port asynchronous SRAM arbiter.
// FSM encoding, SRAM geometry and the inactive level of the control strobes.
package sram_pkg;
    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } sram_req_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake for both ports plus the SRAM pin bundle.
// The arbiter takes the slave view; user logic / board model takes the master view.
interface sram_arbiter_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        be0, be1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_doe;
    logic [DATA_W-1:0] ram_din;
    logic              ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, ram_din,
        output ack0, ack1, rdata, busy, ram_adr, ram_dout, ram_doe,
               ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, ram_din,
        input  ack0, ack1, rdata, busy, ram_adr, ram_dout, ram_doe,
               ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin picker; last_grant advances only when a grant is taken.
// Reset leaves last_grant at 1 so port 0 wins the first contention.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       grant_o,
    output logic       grant_valid_o
);
    logic last_q, last_d;

    always_comb begin
        grant_valid_o = |req_i;
        grant_o       = (&req_i) ? ~last_q : req_i[1];
        last_d        = advance_i ? grant_o : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between two requesters: round-robin grant,
// IDLE->SETUP->STROBE(xWAIT_CYCLES)->HOLD strobe sequencing, registered outputs.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    sram_arbiter_if.slave bus
);
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              doe_q, doe_d;
    logic              cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;

    logic      gnt, gnt_vld;
    sram_req_t req_sel;

    sram_rr_arbiter u_rr (
        .clk           (clk),
        .rst           (rst),
        .req_i         ({bus.req1, bus.req0}),
        .advance_i     ((state_q == ST_IDLE) && gnt_vld),
        .grant_o       (gnt),
        .grant_valid_o (gnt_vld)
    );

    always_comb begin
        if (gnt) req_sel = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1, be: bus.be1};
        else     req_sel = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0, be: bus.be0};
    end

    // Outputs are registered, so each state's strobe levels are loaded on the edge entering it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        doe_d   = doe_q;
        cs_n_d  = cs_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        lb_n_d  = lb_n_q;
        ub_n_d  = ub_n_q;
        busy_d  = busy_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_SETUP;
                    port_d  = gnt;
                    we_d    = req_sel.we;
                    adr_d   = req_sel.addr;
                    cs_n_d  = STROBE_ON;
                    we_n_d  = STROBE_OFF;
                    busy_d  = 1'b1;
                    if (req_sel.we) begin
                        doe_d  = 1'b1;
                        dout_d = req_sel.wdata;
                        oe_n_d = STROBE_OFF;
                        lb_n_d = ~req_sel.be[0];
                        ub_n_d = ~req_sel.be[1];
                    end else begin
                        doe_d  = 1'b0;
                        oe_n_d = STROBE_ON;
                        lb_n_d = STROBE_ON;
                        ub_n_d = STROBE_ON;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                if (we_q) we_n_d = STROBE_ON;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    we_n_d  = STROBE_OFF;
                    oe_n_d  = STROBE_OFF;
                    if (!we_q) rdata_d = bus.ram_din;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                cs_n_d  = STROBE_OFF;
                oe_n_d  = STROBE_OFF;
                we_n_d  = STROBE_OFF;
                lb_n_d  = STROBE_OFF;
                ub_n_d  = STROBE_OFF;
                doe_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            doe_q   <= 1'b0;
            cs_n_q  <= STROBE_OFF;
            oe_n_q  <= STROBE_OFF;
            we_n_q  <= STROBE_OFF;
            lb_n_q  <= STROBE_OFF;
            ub_n_q  <= STROBE_OFF;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            doe_q   <= doe_d;
            cs_n_q  <= cs_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.ram_adr  = adr_q;
    assign bus.ram_dout = dout_q;
    assign bus.ram_doe  = doe_q;
    assign bus.ram_cs_n = cs_n_q;
    assign bus.ram_oe_n = oe_n_q;
    assign bus.ram_we_n = we_n_q;
    assign bus.ram_lb_n = lb_n_q;
    assign bus.ram_ub_n = ub_n_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a default build against a behavioural SRAM model and
// a WAIT_CYCLES=1 build against a constant data bus.
module tb_sram_arbiter;
    typedef struct packed {
        logic        port;
        logic        we;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_data;
        logic        exp_lb_n;
        logic        exp_ub_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    sram_arbiter_if bus_a ();
    sram_arbiter_if bus_b ();

    sram_arbiter #(.WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    sram_arbiter #(.WAIT_CYCLES(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    // SRAM model: lanes written on each clock where cs_n and we_n are both low.
    logic [15:0] mem [logic [18:0]];
    logic [15:0] mw;
    always @(posedge clk) begin
        if (!bus_a.ram_cs_n && !bus_a.ram_we_n) begin
            mw = mem.exists(bus_a.ram_adr) ? mem[bus_a.ram_adr] : 16'h0000;
            if (!bus_a.ram_lb_n) mw[7:0]  = bus_a.ram_dout[7:0];
            if (!bus_a.ram_ub_n) mw[15:8] = bus_a.ram_dout[15:8];
            mem[bus_a.ram_adr] = mw;
        end
    end
    always @(negedge clk) begin
        if (!bus_a.ram_oe_n && mem.exists(bus_a.ram_adr)) bus_a.ram_din = mem[bus_a.ram_adr];
        else                                              bus_a.ram_din = 16'h0000;
    end
    assign bus_b.ram_din = 16'h3C5A;

    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issues one access on bus_a at a negedge and checks it through to the ack.
    task automatic run_vec(input string nm, input vec_t v);
        int lat, welo, busyc;
        logic lane_bad, other;
        logic [15:0] rd;
        lat = 0; welo = 0; busyc = 0; lane_bad = 1'b0; other = 1'b0; rd = '0;
        if (v.port) begin
            bus_a.we1 = v.we; bus_a.addr1 = v.addr; bus_a.wdata1 = v.wdata; bus_a.be1 = v.be; bus_a.req1 = 1'b1;
        end else begin
            bus_a.we0 = v.we; bus_a.addr0 = v.addr; bus_a.wdata0 = v.wdata; bus_a.be0 = v.be; bus_a.req0 = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!bus_a.ram_we_n) welo++;
            if (bus_a.busy) busyc++;
            if (!bus_a.ram_cs_n && (bus_a.ram_lb_n !== v.exp_lb_n || bus_a.ram_ub_n !== v.exp_ub_n)) lane_bad = 1'b1;
            if (v.port ? bus_a.ack0 : bus_a.ack1) other = 1'b1;
            if (v.port ? bus_a.ack1 : bus_a.ack0) begin
                lat = k;
                rd  = bus_a.rdata;
                break;
            end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_we_low_cycles"}, welo, v.we ? 2 : 0);
        chk({nm, "_busy_cycles"}, busyc, 4);
        chk({nm, "_lanes"}, lane_bad, 0);
        chk({nm, "_other_ack"}, other, 0);
        if (v.we) chk({nm, "_mem"}, mem_rd(v.addr), v.exp_data);
        else      chk({nm, "_rdata"}, rd, v.exp_data);
        @(negedge clk);
    endtask

    vec_t vecs [10];
    int   ev_port [3];
    int   ev_k [3];
    int   nev, acks, lat_b, oelo_b;
    logic [15:0] rd_b;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //                port  we    addr       wdata     be     exp       lb_n  ub_n
        vecs[0] = '{1'b0, 1'b1, 19'h12345, 16'hA5C3, 2'b11, 16'hA5C3, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 19'h12345, 16'h0000, 2'b00, 16'hA5C3, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 19'h00010, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 19'h00010, 16'h00FF, 2'b01, 16'hBEFF, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 19'h00010, 16'h0000, 2'b10, 16'hBEFF, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 19'h7FFFF, 16'h5555, 2'b11, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 19'h7FFFF, 16'hCAFE, 2'b00, 16'h5555, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 19'h7FFFF, 16'h0000, 2'b11, 16'h5555, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 19'h7FFFF, 16'hABCD, 2'b10, 16'hAB55, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 19'h7FFFF, 16'h0000, 2'b01, 16'hAB55, 1'b0, 1'b0};

        bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
        bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
        bus_a.be0 = '0; bus_a.be1 = '0; bus_a.ram_din = '0;
        bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
        bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
        bus_b.be0 = '0; bus_b.be1 = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state: {cs_n,oe_n,we_n,lb_n,ub_n,doe,ack0,ack1,busy}
        chk("reset_ctrl", {bus_a.ram_cs_n, bus_a.ram_oe_n, bus_a.ram_we_n, bus_a.ram_lb_n,
                           bus_a.ram_ub_n, bus_a.ram_doe, bus_a.ack0, bus_a.ack1, bus_a.busy}, 9'b111110000);
        chk("reset_adr", bus_a.ram_adr, 0);
        chk("reset_dout_rdata", {bus_a.ram_dout, bus_a.rdata}, 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Contention straight out of reset, both requests held.
        bus_a.addr0 = 19'h00100; bus_a.addr1 = 19'h00200;
        bus_a.req0 = 1'b1; bus_a.req1 = 1'b1;
        nev = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus_a.ack0 && nev < 3) begin ev_port[nev] = 0; ev_k[nev] = k; nev++; end
            if (bus_a.ack1 && nev < 3) begin ev_port[nev] = 1; ev_k[nev] = k; nev++; end
        end
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        chk("contention_count", nev, 3);
        if (nev == 3) begin
            chk("contention_ev0", {ev_port[0][7:0], ev_k[0][7:0]}, {8'd0, 8'd4});
            chk("contention_ev1", {ev_port[1][7:0], ev_k[1][7:0]}, {8'd1, 8'd9});
            chk("contention_ev2", {ev_port[2][7:0], ev_k[2][7:0]}, {8'd0, 8'd14});
        end
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset during the STROBE phase of a write.
        bus_a.we0 = 1'b1; bus_a.addr0 = 19'h00020; bus_a.wdata0 = 16'h1111; bus_a.be0 = 2'b11;
        bus_a.req0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_in_strobe_we_n", bus_a.ram_we_n, 0);
        rst_a = 1'b1; bus_a.req0 = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", {bus_a.ram_we_n, bus_a.ram_cs_n, bus_a.ram_doe, bus_a.busy}, 4'b1100);
        rst_a = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.ack0 || bus_a.ack1) acks++;
        end
        chk("midrst_no_ack", acks, 0);
        run_vec("after_rst", '{1'b1, 1'b0, 19'h12345, 16'h0000, 2'b11, 16'hA5C3, 1'b0, 1'b0});

        // WAIT_CYCLES=1 build: a single read.
        bus_b.we0 = 1'b0; bus_b.addr0 = 19'h00ABC; bus_b.req0 = 1'b1;
        lat_b = 0; oelo_b = 0; rd_b = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!bus_b.ram_oe_n) oelo_b++;
            if (bus_b.ack0) begin lat_b = k; rd_b = bus_b.rdata; break; end
        end
        bus_b.req0 = 1'b0;
        chk("w1_latency", lat_b, 3);
        chk("w1_oe_low_cycles", oelo_b, 2);
        chk("w1_rdata", rd_b, 16'h3C5A);
        chk("w1_adr", bus_b.ram_adr, 19'h00ABC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
